flash_dma_ctrl: RTL and testbench
=================================

Name: flash_dma_ctrl

Overview:
Single-channel DMA engine that copies a block of bytes from SPI flash into PSRAM. It sits between the flash controller (byte-sequential reads) and the PSRAM controller wrapper (byte writes), and is triggered by a one-cycle start pulse. It moves one byte at a time, strictly serialised: flash read, then PSRAM write, then next flash read.

Parameters:
None (all widths fixed: flash 24-bit, PSRAM 22-bit, length 16-bit).

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
flash_src_addr  in  24  flash byte address of first source byte; sampled on accepted start
psram_dst_addr  in  22  PSRAM byte address of first destination byte; sampled on accepted start
data_length  in  16  number of bytes to copy; sampled on accepted start
start  in  1  one-cycle start pulse
busy  out  1  high from the cycle after an accepted start until the transfer completes
flash_addr  out  24  latched source address, held for the whole transfer
flash_req_r_addr  out  1  one-cycle pulse: random-access read at flash_addr
flash_req_r_next  out  1  one-cycle pulse: read next sequential flash byte
flash_d_ready  in  1  one-cycle pulse: flash_d_out is valid
flash_d_out  in  8  flash read data
psram_w_strobe  out  1  one-cycle PSRAM write request
psram_addr  out  22  PSRAM byte address for the current write
psram_d_in  out  16  write data: captured byte replicated on both lanes, {b,b}
psram_busy  in  1  PSRAM controller busy

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE; busy=0, flash_req_r_addr=0, flash_req_r_next=0, psram_w_strobe=0; flash_addr=0, psram_addr=0, psram_d_in=0, counters=0. Reset mid-transfer aborts immediately; no further requests are issued.
- States: IDLE, F_REQ, F_WAIT, P_WAIT_IDLE, P_STROBE, P_SETTLE, P_WAIT_DONE, F_NEXT.
- IDLE: if start=1, latch src, dst and length, clear the byte counter, and set busy=1. If length=0, busy goes high for exactly one cycle and the engine returns to IDLE with no requests. Otherwise go to F_REQ. A start pulse while busy is ignored.
- F_REQ: drive flash_req_r_addr=1 for one cycle, with flash_addr=src; go to F_WAIT.
- F_WAIT: wait for flash_d_ready. On that edge, capture flash_d_out into psram_d_in as {b,b}; go to P_WAIT_IDLE.
- P_WAIT_IDLE: when psram_busy=0, go to P_STROBE.
- P_STROBE: drive psram_w_strobe=1 for one cycle, with psram_addr = dst + count (mod 2^22); go to P_SETTLE.
- P_SETTLE: one-cycle gap so the controller can raise busy; go to P_WAIT_DONE.
- P_WAIT_DONE: when psram_busy=0, increment count.
  - If count+1 = length: busy=0 on the next cycle, go to IDLE.
  - Otherwise go to F_NEXT.
- F_NEXT: drive flash_req_r_next=1 for one cycle; go to F_WAIT.
- Request outputs are registered single-cycle pulses and are never asserted simultaneously.
- psram_addr and psram_d_in remain stable from P_STROBE until the next capture.
- Byte count is 16-bit; length 65535 is the maximum.
- PSRAM address wraps at 2^22. The flash address is not incremented by this block; sequencing beyond the first byte relies on the flash controller's next-read mechanism.
- flash_d_ready pulses outside F_WAIT are ignored.

Test Plan:
- src=A1B200, dst=03D400, length=8, start pulsed one cycle after reset release -> one flash_req_r_addr with flash_addr=A1B200, then 7 flash_req_r_next pulses; 8 psram_w_strobe pulses at addresses 03D400..03D407; each psram_d_in = {byte,byte} of the matching flash byte; busy falls after the 8th write completes, well within 12 µs at 32 MHz.
- start pulsed again mid-transfer -> ignored; still exactly 8 writes, addresses unchanged.
- length=0 -> busy high for exactly one cycle; no flash or PSRAM requests.
- psram_busy forced high for 20 cycles before the 3rd write -> no strobe while busy; the write occurs after release with correct address and data; no byte lost.
- dst=3FFFFE, length=4 -> writes to 3FFFFE, 3FFFFF, 000000, 000001.
- reset_n low for one cycle during the 4th byte -> all outputs return to reset values; no further pulses; a new start runs a full transfer correctly.

Source files
------------

// File: rtl/flash_dma_ctrl.sv
// Single-channel byte DMA: copies data_length bytes from SPI flash into PSRAM,
// one strictly serialised flash-read / PSRAM-write pair at a time.
module flash_dma_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] flash_src_addr,
    input  logic [21:0] psram_dst_addr,
    input  logic [15:0] data_length,
    input  logic        start,
    output logic        busy,
    output logic [23:0] flash_addr,
    output logic        flash_req_r_addr,
    output logic        flash_req_r_next,
    input  logic        flash_d_ready,
    input  logic [7:0]  flash_d_out,
    output logic        psram_w_strobe,
    output logic [21:0] psram_addr,
    output logic [15:0] psram_d_in,
    input  logic        psram_busy
);

    typedef enum logic [2:0] {
        IDLE,
        F_REQ,
        F_WAIT,
        P_WAIT_IDLE,
        P_STROBE,
        P_SETTLE,
        P_WAIT_DONE,
        F_NEXT
    } state_t;

    state_t      state;
    logic [21:0] dst;
    logic [15:0] len;
    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            busy             <= 1'b0;
            flash_addr       <= '0;
            flash_req_r_addr <= 1'b0;
            flash_req_r_next <= 1'b0;
            psram_w_strobe   <= 1'b0;
            psram_addr       <= '0;
            psram_d_in       <= '0;
            dst              <= '0;
            len              <= '0;
            count            <= '0;
        end else begin
            // NOTE: request outputs default low every cycle, so a state that
            // sets one produces exactly one registered pulse.
            flash_req_r_addr <= 1'b0;
            flash_req_r_next <= 1'b0;
            psram_w_strobe   <= 1'b0;

            case (state)
                IDLE: begin
                    // busy can only be high here after a zero-length start
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        flash_addr <= flash_src_addr;
                        dst        <= psram_dst_addr;
                        len        <= data_length;
                        count      <= '0;
                        busy       <= 1'b1;
                        if (data_length != 16'd0)
                            state <= F_REQ;
                    end
                end
                F_REQ: begin
                    flash_req_r_addr <= 1'b1;
                    state            <= F_WAIT;
                end
                F_WAIT: begin
                    if (flash_d_ready) begin
                        psram_d_in <= {flash_d_out, flash_d_out};
                        state      <= P_WAIT_IDLE;
                    end
                end
                P_WAIT_IDLE: begin
                    if (!psram_busy)
                        state <= P_STROBE;
                end
                P_STROBE: begin
                    psram_w_strobe <= 1'b1;
                    psram_addr     <= dst + {6'd0, count};
                    state          <= P_SETTLE;
                end
                P_SETTLE: begin
                    // give the PSRAM controller a cycle to raise its busy flag
                    state <= P_WAIT_DONE;
                end
                P_WAIT_DONE: begin
                    if (!psram_busy) begin
                        count <= count + 16'd1;
                        if (count + 16'd1 == len) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= F_NEXT;
                        end
                    end
                end
                F_NEXT: begin
                    flash_req_r_next <= 1'b1;
                    state            <= F_WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_dma_ctrl.sv
// Self-checking bench for flash_dma_ctrl: behavioural flash and PSRAM models,
// a table of transfer vectors, and hand-written reset/abort sequences.
`timescale 1ns/1ps
module tb_flash_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] flash_src_addr;
    logic [21:0] psram_dst_addr;
    logic [15:0] data_length;
    logic        start;
    logic        busy;
    logic [23:0] flash_addr;
    logic        flash_req_r_addr;
    logic        flash_req_r_next;
    logic        flash_d_ready;
    logic [7:0]  flash_d_out;
    logic        psram_w_strobe;
    logic [21:0] psram_addr;
    logic [15:0] psram_d_in;
    logic        psram_busy;

    always #15.625 clk = ~clk;  // 32 MHz

    flash_dma_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flash_src_addr   (flash_src_addr),
        .psram_dst_addr   (psram_dst_addr),
        .data_length      (data_length),
        .start            (start),
        .busy             (busy),
        .flash_addr       (flash_addr),
        .flash_req_r_addr (flash_req_r_addr),
        .flash_req_r_next (flash_req_r_next),
        .flash_d_ready    (flash_d_ready),
        .flash_d_out      (flash_d_out),
        .psram_w_strobe   (psram_w_strobe),
        .psram_addr       (psram_addr),
        .psram_d_in       (psram_d_in),
        .psram_busy       (psram_busy)
    );

    typedef struct {
        logic [23:0] src;
        logic [21:0] dst;
        logic [15:0] len;
        int          stall_before;  // write index (1-based) preceded by a 20-cycle PSRAM stall, 0 = none
        bit          restart;       // fire a second start mid-transfer
        int          exp_writes;
        logic [21:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor / model state
    logic [21:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          raddr_cnt, rnext_cnt, overlap_cnt, viol_cnt, busy_cyc;
    logic [23:0] fa_seen;
    int          fl_cnt = 0;
    int          fl_seq = 0;
    logic [23:0] fl_base = '0;
    int          ps_cnt = 0;
    int          stall_before = 0;

    function automatic logic [7:0] fbyte(input logic [23:0] a, input int i);
        logic [7:0] k;
        k = 8'(i * 37 + 11);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Flash and PSRAM models plus output monitor, all on the falling edge.
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (32'(flash_req_r_addr) + 32'(flash_req_r_next) + 32'(psram_w_strobe) > 1)
            overlap_cnt++;

        flash_d_ready = 1'b0;
        if (fl_cnt > 0) begin
            fl_cnt--;
            if (fl_cnt == 0) begin
                flash_d_ready = 1'b1;
                flash_d_out   = fbyte(fl_base, fl_seq);
                fl_seq++;
            end
        end
        if (flash_req_r_addr) begin
            raddr_cnt++;
            fa_seen = flash_addr;
            fl_base = flash_addr;
            fl_seq  = 0;
            fl_cnt  = 2;
        end
        if (flash_req_r_next) begin
            rnext_cnt++;
            fl_cnt = 2;
        end

        if (psram_w_strobe) begin
            if (psram_busy) viol_cnt++;
            wr_addr.push_back(psram_addr);
            wr_data.push_back(psram_d_in);
            ps_cnt     = (wr_addr.size() == stall_before - 1) ? 20 : 3;
            psram_busy = 1'b1;
        end else begin
            if (ps_cnt > 0) ps_cnt--;
            psram_busy = (ps_cnt > 0);
        end
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        raddr_cnt = 0; rnext_cnt = 0; overlap_cnt = 0; viol_cnt = 0; busy_cyc = 0;
        fa_seen = '0;
    endtask

    task automatic run(input vec_t v, input string tag);
        int cyc;
        int nxt;
        logic [21:0] ea;
        logic [7:0]  b;
        @(negedge clk);
        clear_mon();
        stall_before   = v.stall_before;
        flash_src_addr = v.src;
        psram_dst_addr = v.dst;
        data_length    = v.len;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.restart) begin
            repeat (15) @(negedge clk);
            check({tag, " busy_at_restart"}, 32'(busy), 32'd1);
            flash_src_addr = 24'hFFFFFF;
            psram_dst_addr = 22'h000000;
            data_length    = 16'd3;
            start          = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_in_budget"}, 32'(busy), 32'd0);
        repeat (10) @(negedge clk);

        nxt = (v.len == 0) ? 0 : int'(v.len) - 1;
        check({tag, " write_count"}, 32'(wr_addr.size()), 32'(v.exp_writes));
        check({tag, " raddr_count"}, 32'(raddr_cnt), (v.len == 0) ? 32'd0 : 32'd1);
        check({tag, " rnext_count"}, 32'(rnext_cnt), 32'(nxt));
        check({tag, " pulse_overlap"}, 32'(overlap_cnt), 32'd0);
        check({tag, " strobe_while_busy"}, 32'(viol_cnt), 32'd0);
        if (v.len == 0) begin
            check({tag, " busy_cycles"}, 32'(busy_cyc), 32'd1);
        end else begin
            check({tag, " flash_addr"}, 32'(fa_seen), 32'(v.src));
            check({tag, " last_addr"}, 32'(wr_addr[wr_addr.size()-1]), 32'(v.exp_last));
            for (int i = 0; i < v.exp_writes && i < wr_addr.size(); i++) begin
                ea = v.dst + 22'(i);
                b  = fbyte(v.src, i);
                check($sformatf("%s wr%0d_addr", tag, i), 32'(wr_addr[i]), 32'(ea));
                check($sformatf("%s wr%0d_data", tag, i), 32'(wr_data[i]), 32'({b, b}));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " pulses"}, 32'({flash_req_r_addr, flash_req_r_next, psram_w_strobe}), 32'd0);
        check({tag, " flash_addr"}, 32'(flash_addr), 32'd0);
        check({tag, " psram_addr"}, 32'(psram_addr), 32'd0);
        check({tag, " psram_d_in"}, 32'(psram_d_in), 32'd0);
    endtask

    initial begin
        int cyc;
        int w_before;
        vecs[0] = '{24'hA1B200, 22'h03D400, 16'd8, 0, 1'b0, 8, 22'h03D407};
        vecs[1] = '{24'hA1B200, 22'h03D400, 16'd8, 0, 1'b1, 8, 22'h03D407};
        vecs[2] = '{24'h000010, 22'h000000, 16'd0, 0, 1'b0, 0, 22'h000000};
        vecs[3] = '{24'h123456, 22'h001000, 16'd5, 3, 1'b0, 5, 22'h001004};
        vecs[4] = '{24'h00FF00, 22'h3FFFFE, 16'd4, 0, 1'b0, 4, 22'h000001};
        vecs[5] = '{24'h7FFFFF, 22'h2AAAAA, 16'd1, 0, 1'b0, 1, 22'h2AAAAA};

        reset_n = 1'b0; start = 1'b0;
        flash_src_addr = '0; psram_dst_addr = '0; data_length = '0;
        flash_d_ready = 1'b0; flash_d_out = '0; psram_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            run(vecs[t], $sformatf("v%0d", t));
            if (t == 0)
                check("v0 within_12us", 32'(busy_cyc < 384), 32'd1);
        end

        // Stray flash_d_ready while idle must not produce a write.
        @(negedge clk);
        clear_mon();
        flash_d_ready = 1'b1; flash_d_out = 8'h5A;
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("stray_ready_writes", 32'(wr_addr.size()), 32'd0);

        // Reset during the 4th byte, then a fresh full transfer.
        clear_mon();
        stall_before   = 0;
        flash_src_addr = 24'hA1B200;
        psram_dst_addr = 22'h03D400;
        data_length    = 16'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rnext_cnt < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("abort reached_4th_byte", 32'(rnext_cnt), 32'd3);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_outputs("abort");
        w_before = wr_addr.size();
        check("abort writes_before", 32'(w_before), 32'd3);
        repeat (30) @(negedge clk);
        check("abort no_more_writes", 32'(wr_addr.size()), 32'(w_before));
        check("abort no_more_rnext", 32'(rnext_cnt), 32'd3);
        check("abort no_more_raddr", 32'(raddr_cnt), 32'd1);
        run(vecs[0], "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
